// File: rtl/branch_trace_driver.sv
// Replays a stored (addr, outcome) trace to a branch predictor one entry per clock and tallies hits/misses.
// Latency: issue registered, PREDICTION compared on the edge ending the issue cycle; no backpressure, free-running once started.
module branch_trace_driver #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              CLOCK,
  input  logic              INIT,
  input  logic              LOAD_EN,
  input  logic [IDX_W-1:0]  LOAD_IDX,
  input  logic [ADDR_W-1:0] LOAD_ADDR,
  input  logic              LOAD_OUTCOME,
  input  logic [IDX_W:0]    LENGTH,
  input  logic [3:0]        REPEAT,
  input  logic              START,
  input  logic              PREDICTION,
  output logic [ADDR_W-1:0] ADDR,
  output logic              OUTCOME,
  output logic              VALID,
  output logic              BUSY,
  output logic              DONE,
  output logic [CNT_W-1:0]  HITS,
  output logic [CNT_W-1:0]  MISS_COUNT,
  output logic [CNT_W-1:0]  ISSUED
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic              mem_out  [DEPTH];

  logic [IDX_W:0]   len_q;
  logic [3:0]       rep_q;
  logic [IDX_W-1:0] ptr;
  logic [3:0]       pass_q;

  logic [IDX_W:0]    eff_len;
  logic [3:0]        eff_rep;
  logic              wr_en;
  logic              start_ok;
  logic              start_run;
  logic              last_in_pass;
  logic              last_pass;
  logic              last_issue;
  logic [IDX_W-1:0]  ptr_nxt;
  logic [IDX_W-1:0]  rd_idx;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_out;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    eff_len      = (LENGTH > DEPTH_L) ? DEPTH_L : LENGTH;
    eff_rep      = (REPEAT == 4'd0) ? 4'd1 : REPEAT;
    wr_en        = LOAD_EN && (state != RUN);
    start_ok     = START && (state != RUN);
    start_run    = start_ok && (eff_len != '0);
    last_in_pass = ({1'b0, ptr} == (len_q - 1'b1));
    last_pass    = (pass_q == (rep_q - 4'd1));
    last_issue   = last_in_pass && last_pass;
    ptr_nxt      = last_in_pass ? '0 : ptr + 1'b1;
    rd_idx       = (state == RUN) ? ptr_nxt : '0;
    // A load landing on the same edge as START must be seen by the first issue.
    if (wr_en && (LOAD_IDX == rd_idx)) begin
      rd_addr = LOAD_ADDR;
      rd_out  = LOAD_OUTCOME;
    end else begin
      rd_addr = mem_addr[rd_idx];
      rd_out  = mem_out[rd_idx];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: begin
        if (start_ok) state_nxt = start_run ? RUN : FIN;
      end
      RUN: begin
        if (last_issue) state_nxt = FIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge INIT) begin
    if (!INIT) state <= IDLE;
    else       state <= state_nxt;
  end

  assign BUSY = (state == RUN);
  assign DONE = (state == FIN);

  always_ff @(posedge CLOCK or negedge INIT) begin
    if (!INIT) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_out[i]  <= 1'b0;
      end
      len_q      <= '0;
      rep_q      <= '0;
      ptr        <= '0;
      pass_q     <= '0;
      ADDR       <= '0;
      OUTCOME    <= 1'b0;
      VALID      <= 1'b0;
      HITS       <= '0;
      MISS_COUNT <= '0;
      ISSUED     <= '0;
    end else begin
      if (wr_en) begin
        mem_addr[LOAD_IDX] <= LOAD_ADDR;
        mem_out[LOAD_IDX]  <= LOAD_OUTCOME;
      end
      if (state == RUN) begin
        // The predictor answers combinationally on the issued address, so score it now.
        if (VALID) begin
          ISSUED <= sat_inc(ISSUED);
          if (PREDICTION == OUTCOME) HITS       <= sat_inc(HITS);
          else                       MISS_COUNT <= sat_inc(MISS_COUNT);
        end
        if (last_issue) begin
          VALID <= 1'b0;
        end else begin
          ADDR    <= rd_addr;
          OUTCOME <= rd_out;
          VALID   <= 1'b1;
          ptr     <= ptr_nxt;
          if (last_in_pass) pass_q <= pass_q + 4'd1;
        end
      end else if (start_ok) begin
        HITS       <= '0;
        MISS_COUNT <= '0;
        ISSUED     <= '0;
        ptr        <= '0;
        pass_q     <= '0;
        len_q      <= eff_len;
        rep_q      <= eff_rep;
        if (start_run) begin
          ADDR    <= rd_addr;
          OUTCOME <= rd_out;
          VALID   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_trace_driver.sv
// Directed bench: drives branch_trace_driver against a 1-bit-per-address predictor model.
module tb_branch_trace_driver;

  logic        CLOCK;
  logic        INIT;
  logic        LOAD_EN;
  logic [3:0]  LOAD_IDX;
  logic [2:0]  LOAD_ADDR;
  logic        LOAD_OUTCOME;
  logic [4:0]  LENGTH;
  logic [3:0]  REPEAT;
  logic        START;
  logic        PREDICTION;
  logic [2:0]  ADDR;
  logic        OUTCOME;
  logic        VALID;
  logic        BUSY;
  logic        DONE;
  logic [15:0] HITS;
  logic [15:0] MISS_COUNT;
  logic [15:0] ISSUED;

  branch_trace_driver dut (
    .CLOCK(CLOCK), .INIT(INIT), .LOAD_EN(LOAD_EN), .LOAD_IDX(LOAD_IDX),
    .LOAD_ADDR(LOAD_ADDR), .LOAD_OUTCOME(LOAD_OUTCOME), .LENGTH(LENGTH),
    .REPEAT(REPEAT), .START(START), .PREDICTION(PREDICTION), .ADDR(ADDR),
    .OUTCOME(OUTCOME), .VALID(VALID), .BUSY(BUSY), .DONE(DONE), .HITS(HITS),
    .MISS_COUNT(MISS_COUNT), .ISSUED(ISSUED)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // 1-bit predictor: predicts the last outcome seen per address, updates every clock.
  logic [7:0] pt;
  int         pred_misses;
  assign PREDICTION = pt[ADDR];
  always @(posedge CLOCK or negedge INIT) begin
    if (!INIT) begin
      pt          <= '0;
      pred_misses <= 0;
    end else begin
      pt[ADDR] <= OUTCOME;
      if (pt[ADDR] != OUTCOME) pred_misses <= pred_misses + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int         busy_n, valid_n, gaps, done_cyc, last_v, dips;
  logic [2:0] cap_addr [0:63];
  logic       cap_out  [0:63];

  task automatic load(input logic [3:0] idx, input logic [2:0] a, input logic o);
    LOAD_EN = 1'b1; LOAD_IDX = idx; LOAD_ADDR = a; LOAD_OUTCOME = o;
    @(negedge CLOCK);
    LOAD_EN = 1'b0;
  endtask

  task automatic pulse_reset();
    INIT = 1'b0;
    repeat (2) @(negedge CLOCK);
    INIT = 1'b1;
    @(negedge CLOCK);
  endtask

  // Starts a replay and samples each following cycle until DONE; kind 1 = load idx2, kind 2 = START.
  task automatic do_run(input string tag, input logic [4:0] len, input logic [3:0] rep,
                        input int inj_cyc, input int inj_kind);
    logic [15:0] prev_issued;
    logic        prev_valid, seen_valid;
    LENGTH = len; REPEAT = rep; START = 1'b1;
    busy_n = 0; valid_n = 0; gaps = 0; done_cyc = -1; last_v = 0; dips = 0;
    prev_issued = '0; prev_valid = 1'b0; seen_valid = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge CLOCK);
      START = 1'b0; LOAD_EN = 1'b0;
      if (BUSY) busy_n++;
      if (VALID) begin
        if (seen_valid && !prev_valid) gaps++;
        seen_valid = 1'b1;
        if (valid_n < 64) begin
          cap_addr[valid_n] = ADDR;
          cap_out[valid_n]  = OUTCOME;
        end
        valid_n++;
        last_v = cyc;
      end
      prev_valid = VALID;
      if (ISSUED < prev_issued) dips++;
      prev_issued = ISSUED;
      if (DONE) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == inj_cyc && inj_kind == 1) begin
        LOAD_EN = 1'b1; LOAD_IDX = 4'd2; LOAD_ADDR = 3'd7; LOAD_OUTCOME = 1'b1;
      end
      if (cyc == inj_cyc && inj_kind == 2) START = 1'b1;
    end
    chk({tag, "_done_seen"}, (done_cyc > 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  int flag, found, pm;

  initial begin
    INIT = 1'b0; LOAD_EN = 1'b0; LOAD_IDX = '0; LOAD_ADDR = '0; LOAD_OUTCOME = 1'b0;
    LENGTH = '0; REPEAT = '0; START = 1'b0;
    repeat (2) @(negedge CLOCK);
    chk("rst_addr", ADDR, 0);
    chk("rst_outcome", OUTCOME, 0);
    chk("rst_valid", VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_hits", HITS, 0);
    chk("rst_miss", MISS_COUNT, 0);
    chk("rst_issued", ISSUED, 0);
    INIT = 1'b1;
    @(negedge CLOCK);

    // Alternating outcomes on one address: every prediction is wrong.
    load(4'd0, 3'd0, 1'b1); load(4'd1, 3'd0, 1'b0);
    load(4'd2, 3'd0, 1'b1); load(4'd3, 3'd0, 1'b0);
    do_run("alt", 5'd4, 4'd1, 0, 0);
    chk("alt_issued", ISSUED, 4);
    chk("alt_hits", HITS, 0);
    chk("alt_miss", MISS_COUNT, 4);
    chk("alt_busy_cycles", busy_n, 4);
    chk("alt_valid_cycles", valid_n, 4);
    chk("alt_done_cycle", done_cyc, 5);
    chk("alt_done_lag", done_cyc - last_v, 1);

    // Two addresses, three passes: only the very first access misses.
    pulse_reset();
    load(4'd0, 3'd0, 1'b1); load(4'd1, 3'd1, 1'b0);
    load(4'd2, 3'd0, 1'b1); load(4'd3, 3'd1, 1'b0);
    do_run("two", 5'd4, 4'd3, 0, 0);
    chk("two_issued", ISSUED, 12);
    chk("two_miss", MISS_COUNT, 1);
    chk("two_hits", HITS, 11);
    chk("two_valid_cycles", valid_n, 12);
    chk("two_valid_gaps", gaps, 0);
    chk("two_busy_cycles", busy_n, 12);

    // Idle hold after DONE.
    repeat (10) @(negedge CLOCK);
    chk("hold_addr", ADDR, 1);
    chk("hold_outcome", OUTCOME, 0);
    chk("hold_hits", HITS, 11);
    chk("hold_issued", ISSUED, 12);
    chk("hold_pred_misses", pred_misses, 1);
    chk("hold_done", DONE, 1);

    // LENGTH=0 from FIN: straight back to DONE with cleared counts.
    do_run("len0", 5'd0, 4'd1, 0, 0);
    chk("len0_done_cycle", done_cyc, 1);
    chk("len0_valid_cycles", valid_n, 0);
    chk("len0_issued", ISSUED, 0);
    chk("len0_hits", HITS, 0);
    chk("len0_miss", MISS_COUNT, 0);

    // LENGTH=20 clamps to 16, REPEAT=0 means one pass.
    do_run("len20", 5'd20, 4'd0, 0, 0);
    chk("len20_issued", ISSUED, 16);
    chk("len20_valid_cycles", valid_n, 16);
    chk("len20_hits", HITS, 15);
    chk("len20_miss", MISS_COUNT, 1);
    chk("len20_entry4_addr", cap_addr[4], 0);

    // Load during RUN is dropped.
    pulse_reset();
    for (int i = 0; i < 4; i++) load(4'(i), 3'(i), 1'b0);
    do_run("gate1", 5'd4, 4'd1, 2, 1);
    chk("gate1_e2_addr", cap_addr[2], 2);
    do_run("gate2", 5'd4, 4'd1, 0, 0);
    chk("gate2_e2_addr", cap_addr[2], 2);
    chk("gate2_e2_out", cap_out[2], 0);
    chk("gate2_hits", HITS, 4);

    // START during RUN is ignored.
    do_run("restart", 5'd8, 4'd1, 3, 2);
    chk("restart_issued", ISSUED, 8);
    chk("restart_busy_cycles", busy_n, 8);
    chk("restart_dips", dips, 0);
    chk("restart_gaps", gaps, 0);

    // Load and START on the same edge: first issue uses the new entry.
    LOAD_EN = 1'b1; LOAD_IDX = 4'd0; LOAD_ADDR = 3'd6; LOAD_OUTCOME = 1'b1;
    do_run("ldst", 5'd1, 4'd1, 0, 0);
    chk("ldst_addr", cap_addr[0], 6);
    chk("ldst_out", cap_out[0], 1);
    chk("ldst_issued", ISSUED, 1);

    // Asynchronous reset in the middle of a replay, at entry 5.
    for (int i = 0; i < 8; i++) load(4'(i), 3'(i), 1'b1);
    LENGTH = 5'd8; REPEAT = 4'd1; START = 1'b1;
    found = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge CLOCK);
      START = 1'b0;
      if (VALID && ADDR == 3'd5) begin
        found = 1;
        break;
      end
    end
    chk("mid_found_entry5", found, 1);
    pm = int'(ISSUED);
    chk("mid_issued_before", pm, 5);
    #1 INIT = 1'b0;
    #1;
    chk("mid_rst_addr", ADDR, 0);
    chk("mid_rst_outcome", OUTCOME, 0);
    chk("mid_rst_valid", VALID, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_done", DONE, 0);
    chk("mid_rst_hits", HITS, 0);
    chk("mid_rst_miss", MISS_COUNT, 0);
    chk("mid_rst_issued", ISSUED, 0);
    @(negedge CLOCK);
    INIT = 1'b1;
    flag = 0;
    repeat (6) begin
      @(negedge CLOCK);
      if (DONE || BUSY || VALID) flag++;
    end
    chk("mid_after_release_idle", flag, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
